register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-read-port integer register file for the RockWave core, replacing the fixed 2-read/32-entry file.
//  Configurable entry count (RV32I 32 / RV32E 16), width and read-port count. Registered reads with valid strobe.
//  Hardware clear sequencer zeroes all entries after reset or on request. x0 reads zero and ignores writes.
//  Sits between decode (read select) and writeback (write port).
// PARAMETERS
//  XLEN     32  data width of each entry
//  NREG     32  number of entries incl. x0; legal values 16 or 32
//  NRD      2   number of read ports, 1..4
//  AW       $clog2(NREG) (localparam)  select width
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst        in   1         synchronous reset, active-high
//  init_req   in   1         pulse: request full clear (honoured only in RUN)
//  ready      out  1         1 = RUN state, reads/writes accepted
//  wr_en      in   1         write strobe (writeback phase)
//  wr_sel     in   AW        write entry index
//  wr_data    in   XLEN      write data
//  wr_drop    out  1         1-cycle pulse: wr_en seen while ready=0, write discarded
//  rd_en      in   NRD       per-port read request
//  rd_sel     in   NRD*AW    port p index at [p*AW +: AW]
//  rd_data    out  NRD*XLEN  port p data at [p*XLEN +: XLEN], registered
//  rd_valid   out  NRD       per-port: rd_data valid this cycle
// BEHAVIOUR
//  Reset (rst=1 at edge): state<=INIT, clr_cnt<=1, ready=0, rd_data=0, rd_valid=0, wr_drop=0. Array contents not reset by rst itself.
//  FSM: INIT -> RUN when clr_cnt==NREG-1 has been written; RUN -> INIT on init_req (clr_cnt<=1). No other transitions.
//  INIT: one entry per cycle, entry[clr_cnt]<=0, clr_cnt++; takes NREG-1 cycles; ready=0 throughout.
//  rst asserted mid-INIT restarts at clr_cnt=1. init_req during INIT ignored.
//  Write (RUN): wr_en & wr_sel!=0 -> entry[wr_sel]<=wr_data at edge. wr_sel==0 silently ignored (no wr_drop).
//  Write while ready=0: discarded, wr_drop=1 next cycle. rd_en while ready=0: rd_valid=0 next cycle, rd_data holds.
//  Read: latency 1. rd_en[p]=1 at edge N -> rd_data[p] = entry[rd_sel[p]] (0 if sel==0), rd_valid[p]=1 during cycle N+1.
//  rd_en[p]=0 -> rd_valid[p]=0, rd_data[p] holds last value.
//  Ports independent; any number may select the same entry.
//  Simultaneous write and read of same entry at same edge: see REGFILE_BYPASS_EN.
//  init_req and wr_en at same edge in RUN: write is performed, then INIT starts (entry later cleared).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-edge wr_en & wr_sel==rd_sel[p]!=0 -> rd_data[p]=wr_data (new value).
//  REGFILE_BYPASS_EN undefined: rd_data[p] = old entry value; new value visible from the next read.
// STRUCTURE
//  Shared include regfile_pkg.vh: state encodings ST_INIT/ST_RUN, NREG legality check, AW computation.
//  Sub-module regfile_clr_seq: INIT/RUN FSM + clr_cnt; outputs ready, clr_we, clr_sel.
//  Top: write mux (clr vs wr port), entry array as reg [XLEN-1:0] mem[1:NREG-1], NRD read slices via generate loop.
// TESTING
//  Reset for 1 cycle, hold -> ready=0 for exactly NREG-1 cycles, then 1; all reads return 0.
//  wr x5=0xDEADBEEF, next cycle rd_en port0 sel=5 -> port0 = 0xDEADBEEF with rd_valid=1 one cycle later.
//  wr x0=0x12345678, read x0 on all ports -> 0x00000000.
//  Same edge: wr x7=0xA5A5A5A5 (x7 old 0x1), read x7 -> 0xA5A5A5A5 with bypass, 0x00000001 without.
//  init_req in RUN with x3=0xFF -> ready drops; wr_en during INIT -> wr_drop pulse; after INIT x3 reads 0.
//  rst asserted at INIT cycle 10 -> INIT restarts, ready rises NREG-1 cycles after rst release.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file: FSM encoding, entry-count legality, select width.
// Pure declarations; no latency or backpressure of its own.
package register_file_mp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  function automatic bit rf_nreg_ok(input int n);
    return (n == 16) || (n == 32);
  endfunction

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_mp_clr_seq.sv
// Clear sequencer: walks entries 1..NREG-1 one per cycle after reset or init_req, then holds RUN.
// Zero latency on outputs (decoded from state); init_req only honoured in RUN.
module register_file_mp_clr_seq
  import register_file_mp_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_sel
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = AW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ready   = (state_q == ST_RUN);
    clr_we  = (state_q == ST_INIT);
    clr_sel = cnt_q;
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised NRD-read / 1-write register file with x0 hard-wired to zero; reads registered, 1-cycle latency.
// While clearing (ready=0) writes are dropped with a wr_drop pulse and reads return no valid. Macro: REGFILE_BYPASS_EN.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              ready,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_sel,
  input  logic [XLEN-1:0]   wr_data,
  output logic              wr_drop,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_valid
);

  if (!rf_nreg_ok(NREG)) begin : g_bad_nreg
    $error("register_file_mp: NREG must be 16 or 32");
  end

  logic            clr_we;
  logic [AW-1:0]   clr_sel;
  logic            user_we;
  logic            mem_we;
  logic [AW-1:0]   mem_wsel;
  logic [XLEN-1:0] mem_wdat;
  logic [XLEN-1:0] mem_q [1:NREG-1];
  logic            wr_drop_q;

  register_file_mp_clr_seq #(.NREG(NREG), .AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_sel  (clr_sel)
  );

  // Clear sequencer owns the write port whenever it is active; x0 has no storage.
  assign user_we  = ready & wr_en & (wr_sel != '0);
  assign mem_we   = clr_we | user_we;
  assign mem_wsel = clr_we ? clr_sel : wr_sel;
  assign mem_wdat = clr_we ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wsel] <= mem_wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= wr_en & ~ready;
  end
  assign wr_drop = wr_drop_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] rdat_d;
    logic [XLEN-1:0] rdat_q;
    logic            rvld_q;

    assign sel = rd_sel[p*AW +: AW];

    always_comb begin
      rdat_d = '0;
      if (sel != '0) rdat_d = mem_q[sel];
`ifdef REGFILE_BYPASS_EN
      if (user_we && (wr_sel == sel)) rdat_d = wr_data;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdat_q <= '0;
        rvld_q <= 1'b0;
      end else begin
        rvld_q <= rd_en[p] & ready;
        if (rd_en[p] && ready) rdat_q <= rdat_d;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = rdat_q;
    assign rd_valid[p]             = rvld_q;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Random + directed stimulus against a behavioural register-file model; expectations queued per cycle and popped by a monitor.
module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, init_req, ready, wr_en, wr_drop;
  logic [AW-1:0]        wr_sel;
  logic [XLEN-1:0]      wr_data;
  logic [NRD-1:0]       rd_en, rd_valid;
  logic [NRD*AW-1:0]    rd_sel;
  logic [NRD*XLEN-1:0]  rd_data;

  register_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  typedef struct {
    int unsigned          tgt;
    logic                 rdy;
    logic                 drop;
    logic [NRD-1:0]       vld;
    logic [NRD*XLEN-1:0]  dat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Reference state: what software would observe, not how the hardware gets there.
  logic [XLEN-1:0]     m_mem [NREG];
  bit                  m_ready = 0;
  int                  m_left = 0;
  logic [NRD*XLEN-1:0] m_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [NRD*AW-1:0] sels(input int a, input int b);
    logic [NRD*AW-1:0] s;
    s = '0;
    s[0 +: AW]  = AW'(a);
    s[AW +: AW] = AW'(b);
    return s;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_ready = 0;
    m_left  = NREG - 1;
  endtask

  task automatic drive(input logic r, input logic ir, input logic we, input logic [AW-1:0] ws,
                       input logic [XLEN-1:0] wd, input logic [NRD-1:0] re, input logic [NRD*AW-1:0] rs);
    exp_t e;
    int   s;
    logic [XLEN-1:0] v;
    @(posedge clk);
    #1;
    rst = r; init_req = ir; wr_en = we; wr_sel = ws; wr_data = wd; rd_en = re; rd_sel = rs;
    e.tgt  = cyc + 1;
    e.drop = 1'b0;
    e.vld  = '0;
    if (r) begin
      m_clear();
      m_dat = '0;
    end else if (!m_ready) begin
      e.drop = we;
      m_left--;
      if (m_left == 0) m_ready = 1;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        s = int'(rs[p*AW +: AW]);
        if (re[p]) begin
          v = (s == 0) ? '0 : m_mem[s];
`ifdef REGFILE_BYPASS_EN
          if (we && s != 0 && int'(ws) == s) v = wd;
`endif
          m_dat[p*XLEN +: XLEN] = v;
        end
      end
      e.vld = re;
      if (we && ws != 0) m_mem[ws] = wd;
      if (ir) m_clear();
    end
    e.rdy = m_ready;
    e.dat = m_dat;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
        e = exp_q.pop_front();
        chk("ready", 128'(ready), 128'(e.rdy));
        chk("wr_drop", 128'(wr_drop), 128'(e.drop));
        chk("rd_valid", 128'(rd_valid), 128'(e.vld));
        chk("rd_data", 128'(rd_data), 128'(e.dat));
      end
    end
  end

  initial begin
    rst = 1'b1; init_req = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_en = '0; rd_sel = '0;

    drive(1, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < NREG + 2; i++)
      drive(0, 0, 1'($urandom), AW'($urandom), $urandom, NRD'($urandom), NRD*AW'($urandom));

    for (int i = 0; i < NREG; i++) drive(0, 0, 0, '0, '0, '1, sels(i, NREG - 1 - i));

    drive(0, 0, 1, AW'(5), 32'hDEADBEEF, '0, '0);
    drive(0, 0, 0, '0, '0, 2'b01, sels(5, 0));
    idle();

    drive(0, 0, 1, AW'(0), 32'h12345678, '0, '0);
    drive(0, 0, 1, AW'(0), 32'h12345678, '1, sels(0, 0));
    drive(0, 0, 0, '0, '0, '1, sels(0, 0));

    drive(0, 0, 1, AW'(7), 32'h00000001, '0, '0);
    drive(0, 0, 1, AW'(7), 32'hA5A5A5A5, '1, sels(7, 7));
    drive(0, 0, 0, '0, '0, '1, sels(7, 5));

    drive(0, 0, 1, AW'(3), 32'h000000FF, '0, '0);
    drive(0, 1, 1, AW'(4), 32'h00000044, '1, sels(3, 4));
    drive(0, 0, 1, AW'(9), 32'h99999999, '1, sels(9, 3));
    drive(0, 1, 0, '0, '0, '0, '0);
    for (int i = 0; i < NREG; i++) idle();
    drive(0, 0, 0, '0, '0, '1, sels(3, 4));

    drive(0, 1, 0, '0, '0, '0, '0);
    for (int i = 0; i < 9; i++) idle();
    drive(1, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < NREG + 1; i++) idle();
    drive(0, 0, 0, '0, '0, '1, sels(9, 5));

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ws;
      logic [NRD*AW-1:0] rs;
      ws = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rs = sels($urandom_range(0, 7), $urandom_range(0, NREG - 1));
      if ($urandom_range(0, 3) == 0) rs[0 +: AW] = ws;
      drive(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 199) == 0), 1'($urandom),
            ws, $urandom, NRD'($urandom), rs);
    end

    idle();
    idle();
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
